// File: rtl/heichips25_fpga_core.sv
`default_nettype none
// ============================================================================
// Module      : heichips25_fpga_core
// Description : Configuration-and-IO core behind the HeiChips25 pad ring.
//               After reset, and when fpga_mode is 1, it reads a 16-byte
//               bitstream from SPI NOR flash (READ 0x03, SPI mode 0). The
//               bitstream is one sync word followed by cfg_oe, cfg_val and
//               cfg_pass. It then drives 32 user IOs from that configuration.
// Ports       : fpga_clk / fpga_rst  - clock, synchronous active-high reset
//               fpga_mode            - 1 = boot from flash, 0 = unconfigured
//               fpga_sclk/cs_n/mosi  - SPI master outputs
//               fpga_miso            - SPI data from flash
//               fpga_config_busy     - high while a load is in progress
//               io_in / io_out / io_oe - user IO pad interface
// Options     : `define HEICHIPS25_SYNC_CHECK_EN makes a sync word mismatch
//               end the load in FAIL, with the IOs left undriven.
// Revision    : 1.0 - initial release
// ============================================================================
module heichips25_fpga_core #(
    parameter int          CLK_DIV    = 1,
    parameter logic [23:0] FLASH_ADDR = 24'h000000,
    parameter logic [31:0] SYNC_WORD  = 32'h5AA5C33C
) (
    input  logic        fpga_clk,
    input  logic        fpga_rst,
    input  logic        fpga_mode,
    output logic        fpga_sclk,
    output logic        fpga_cs_n,
    output logic        fpga_mosi,
    input  logic        fpga_miso,
    output logic        fpga_config_busy,
    input  logic [31:0] io_in,
    output logic [31:0] io_out,
    output logic [31:0] io_oe
);

    localparam int               DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_DIV - 1);
    localparam logic [31:0]      CMD_WORD  = {8'h03, FLASH_ADDR};
    localparam logic [7:0]       LAST_CMD  = 8'd31;
    localparam logic [7:0]       LAST_BIT  = 8'd159;
`ifdef HEICHIPS25_SYNC_CHECK_EN
    localparam logic             CHECK_EN  = 1'b1;
`else
    localparam logic             CHECK_EN  = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_FAIL = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               armed_q;        // set only in the first cycle after reset
    logic [DIV_W-1:0]   div_q;
    logic [7:0]         bit_q;          // index of the bit currently on the wire
    logic               sclk_q, cs_n_q, mosi_q, busy_q;
    logic [31:0]        cmd_sr_q;
    logic [127:0]       data_sr_q;
    logic [31:0]        cfg_oe_q, cfg_val_q, cfg_pass_q;

    logic               active, tick, rise, fall, last, sync_ok;
    logic [31:0]        rotated;

    always_comb begin
        active  = (state_q == S_CMD) || (state_q == S_DATA);
        tick    = active && (div_q == DIV_MAX);
        rise    = tick && !sclk_q;
        fall    = tick && sclk_q;
        last    = fall && (bit_q == LAST_BIT);
        // With the check disabled the sync word is discarded and always accepted.
        sync_ok = (data_sr_q[127:96] == SYNC_WORD) || !CHECK_EN;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (armed_q && fpga_mode) state_d = S_CMD;
            S_CMD:   if (fall && bit_q == LAST_CMD) state_d = S_DATA;
            S_DATA:  if (last) state_d = sync_ok ? S_DONE : S_FAIL;
            S_DONE:  state_d = S_DONE;
            S_FAIL:  state_d = S_FAIL;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge fpga_clk) begin
        if (fpga_rst) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b1;
            div_q      <= '0;
            bit_q      <= '0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            cmd_sr_q   <= '0;
            data_sr_q  <= '0;
            cfg_oe_q   <= '0;
            cfg_val_q  <= '0;
            cfg_pass_q <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b0;
            if (state_q == S_IDLE && state_d == S_CMD) begin
                // Load start: first command bit is presented immediately.
                busy_q   <= 1'b1;
                cs_n_q   <= 1'b0;
                sclk_q   <= 1'b0;
                div_q    <= '0;
                bit_q    <= '0;
                mosi_q   <= CMD_WORD[31];
                cmd_sr_q <= {CMD_WORD[30:0], 1'b0};
            end else if (active) begin
                if (tick) begin
                    div_q  <= '0;
                    sclk_q <= ~sclk_q;
                end else begin
                    div_q  <= div_q + 1'b1;
                end
                if (rise && bit_q > LAST_CMD) begin
                    data_sr_q <= {data_sr_q[126:0], fpga_miso};
                end
                if (last) begin
                    busy_q <= 1'b0;
                    cs_n_q <= 1'b1;
                    mosi_q <= 1'b0;
                    if (sync_ok) begin
                        cfg_oe_q   <= data_sr_q[95:64];
                        cfg_val_q  <= data_sr_q[63:32];
                        cfg_pass_q <= data_sr_q[31:0];
                    end
                end else if (fall) begin
                    bit_q <= bit_q + 8'd1;
                    if (bit_q < LAST_CMD) begin
                        mosi_q   <= cmd_sr_q[31];
                        cmd_sr_q <= {cmd_sr_q[30:0], 1'b0};
                    end else begin
                        mosi_q   <= 1'b0;
                    end
                end
            end
        end
    end

    // io_out[i] takes io_in[(i+16) mod 32] on pass-through bits.
    always_comb begin
        rotated = {io_in[15:0], io_in[31:16]};
        io_oe   = cfg_oe_q;
        io_out  = cfg_oe_q & ((cfg_pass_q & rotated) | (~cfg_pass_q & cfg_val_q));
    end

    assign fpga_sclk        = sclk_q;
    assign fpga_cs_n        = cs_n_q;
    assign fpga_mosi        = mosi_q;
    assign fpga_config_busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_heichips25_fpga_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_heichips25_fpga_core
// Description : Self-checking bench for heichips25_fpga_core with a
//               behavioural SPI flash model and table-driven load vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_heichips25_fpga_core;

    logic        fpga_clk = 1'b0;
    logic        fpga_rst = 1'b1;
    logic        fpga_mode = 1'b0;
    logic        fpga_sclk, fpga_cs_n, fpga_mosi, fpga_miso, fpga_config_busy;
    logic [31:0] io_in = '0;
    logic [31:0] io_out, io_oe;

    heichips25_fpga_core dut (
        .fpga_clk         (fpga_clk),
        .fpga_rst         (fpga_rst),
        .fpga_mode        (fpga_mode),
        .fpga_sclk        (fpga_sclk),
        .fpga_cs_n        (fpga_cs_n),
        .fpga_mosi        (fpga_mosi),
        .fpga_miso        (fpga_miso),
        .fpga_config_busy (fpga_config_busy),
        .io_in            (io_in),
        .io_out           (io_out),
        .io_oe            (io_oe)
    );

    always #5 fpga_clk = ~fpga_clk;

    // Flash model: counts sclk rising edges, captures the command, serves data.
    logic [127:0] flash_bits = '0;
    logic         sclk_prev;
    int           rise_cnt;
    logic [31:0]  cmd_cap;
    logic         mosi_err;

    always @(posedge fpga_clk) begin
        sclk_prev <= fpga_sclk;
        if (fpga_rst) begin
            rise_cnt <= 0;
            cmd_cap  <= '0;
            mosi_err <= 1'b0;
        end else if (fpga_sclk && !sclk_prev) begin
            rise_cnt <= rise_cnt + 1;
            if (rise_cnt < 32) cmd_cap <= {cmd_cap[30:0], fpga_mosi};
            else if (fpga_mosi) mosi_err <= 1'b1;
        end
    end

    always_comb begin
        fpga_miso = 1'b0;
        if (rise_cnt >= 32 && rise_cnt < 160) fpga_miso = flash_bits[127 - (rise_cnt - 32)];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reset, release with the given mode, and count busy cycles (bounded).
    task automatic run_load(input logic mode, output int busy_cycles);
        fpga_rst  = 1'b1;
        fpga_mode = mode;
        repeat (3) @(negedge fpga_clk);
        fpga_rst = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge fpga_clk);
            if (fpga_config_busy) busy_cycles++;
            else if (busy_cycles > 0) break;
        end
    endtask

    typedef struct {
        string       name;
        logic        mode;
        logic [31:0] w0, w1, w2, w3;
        logic [31:0] din;
        logic [31:0] exp_oe, exp_out, exp_cmd;
        int          exp_rises, exp_busy;
    } vec_t;

    vec_t vecs[5];
    int   bc;

    initial begin
`ifdef HEICHIPS25_SYNC_CHECK_EN
        logic [31:0] bad_oe  = 32'h00000000;
        logic [31:0] bad_out = 32'h00000000;
`else
        logic [31:0] bad_oe  = 32'hFFFFFFFF;
        logic [31:0] bad_out = 32'h12345678;
`endif
        vecs[0] = '{"mode0",  1'b0, 32'h5AA5C33C, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,
                    32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 0, 0};
        vecs[1] = '{"static", 1'b1, 32'h5AA5C33C, 32'h0000FFFF, 32'h0000A5A5, 32'h0,
                    32'hFFFFFFFF, 32'h0000FFFF, 32'h0000A5A5, 32'h03000000, 160, 320};
        vecs[2] = '{"pass",   1'b1, 32'h5AA5C33C, 32'hFFFF0000, 32'h0, 32'hFFFF0000,
                    32'h00001234, 32'hFFFF0000, 32'h12340000, 32'h03000000, 160, 320};
        vecs[3] = '{"badsync", 1'b1, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h12345678, 32'h0,
                    32'h0, bad_oe, bad_out, 32'h03000000, 160, 320};
        vecs[4] = '{"mixed",  1'b1, 32'h5AA5C33C, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'h0000FFFF,
                    32'h55550000, 32'hFFFFFFFF, 32'hAAAA5555, 32'h03000000, 160, 320};

        // Reset state
        repeat (2) @(negedge fpga_clk);
        chk("rst_busy", {31'h0, fpga_config_busy}, 32'h0);
        chk("rst_cs_n", {31'h0, fpga_cs_n}, 32'h1);
        chk("rst_sclk", {31'h0, fpga_sclk}, 32'h0);
        chk("rst_mosi", {31'h0, fpga_mosi}, 32'h0);
        chk("rst_oe", io_oe, 32'h0);
        chk("rst_out", io_out, 32'h0);

        for (int v = 0; v < 5; v++) begin
            flash_bits = {vecs[v].w0, vecs[v].w1, vecs[v].w2, vecs[v].w3};
            io_in = vecs[v].din;
            run_load(vecs[v].mode, bc);
            if (vecs[v].mode == 1'b0) repeat (10) @(negedge fpga_clk);
            chk({vecs[v].name, "_busy_cycles"}, bc, vecs[v].exp_busy);
            chk({vecs[v].name, "_rises"}, rise_cnt, vecs[v].exp_rises);
            chk({vecs[v].name, "_cmd"}, cmd_cap, vecs[v].exp_cmd);
            chk({vecs[v].name, "_mosi_data"}, {31'h0, mosi_err}, 32'h0);
            chk({vecs[v].name, "_cs_n"}, {31'h0, fpga_cs_n}, 32'h1);
            chk({vecs[v].name, "_sclk"}, {31'h0, fpga_sclk}, 32'h0);
            chk({vecs[v].name, "_oe"}, io_oe, vecs[v].exp_oe);
            chk({vecs[v].name, "_out"}, io_out, vecs[v].exp_out);
        end

        // Pass-through is combinational: change io_in with config from "mixed".
        io_in = 32'hABCD0000;
        #1;
        chk("comb_pass_out", io_out, 32'hAAAAABCD);
        io_in = 32'h0000FFFF;
        #1;
        chk("comb_pass_out2", io_out, 32'hAAAA0000);

        // Reset mid-load at cycle 100, then a full reload.
        flash_bits = {32'h5AA5C33C, 32'h0000FFFF, 32'h0000A5A5, 32'h0};
        fpga_rst  = 1'b1;
        fpga_mode = 1'b1;
        repeat (3) @(negedge fpga_clk);
        fpga_rst = 1'b0;
        repeat (100) @(negedge fpga_clk);
        chk("midload_busy_before", {31'h0, fpga_config_busy}, 32'h1);
        fpga_rst = 1'b1;
        @(negedge fpga_clk);
        chk("midload_cs_n", {31'h0, fpga_cs_n}, 32'h1);
        chk("midload_busy", {31'h0, fpga_config_busy}, 32'h0);
        chk("midload_sclk", {31'h0, fpga_sclk}, 32'h0);
        chk("midload_oe", io_oe, 32'h0);

        flash_bits = {32'h5AA5C33C, 32'hFFFF0000, 32'h0, 32'hFFFF0000};
        io_in = 32'h00001234;
        run_load(1'b1, bc);
        chk("reload_busy_cycles", bc, 320);
        chk("reload_rises", rise_cnt, 160);
        chk("reload_oe", io_oe, 32'hFFFF0000);
        chk("reload_out", io_out, 32'h12340000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/heichips25_fpga_core.md
# heichips25_fpga_core

Configuration-and-IO core behind the HeiChips25 pad ring. After reset it optionally boots from an external SPI NOR flash (standard READ 0x03), loads a 16-byte bitstream into configuration registers, then drives 32 user IOs from that configuration. The pad ring wraps this block; tristate pads are built from `io_out` and `io_oe`.

## Interface
Parameters:
- `CLK_DIV`, default 1: `fpga_sclk` half-period in `fpga_clk` cycles (≥1).
- `FLASH_ADDR`, default 24'h000000: flash byte address of the bitstream.
- `SYNC_WORD`, default 32'h5AA5C33C: expected first bitstream word.

Ports:
- `fpga_clk` in 1: sole clock; all logic rising-edge.
- `fpga_rst` in 1: reset; synchronous and active-high.
- `fpga_mode` in 1: boot mode; 1 = load from flash, 0 = stay unconfigured.
- `fpga_sclk` out 1: SPI clock, mode 0.
- `fpga_cs_n` out 1: SPI chip select, active-low.
- `fpga_mosi` out 1: SPI data to flash.
- `fpga_miso` in 1: SPI data from flash.
- `fpga_config_busy` out 1: high while a load is in progress.
- `io_in` in 32: pad input values.
- `io_out` out 32: pad output values.
- `io_oe` out 32: pad output enables, 1 = drive.

## Operation
- Reset values: `fpga_sclk`=0, `fpga_cs_n`=1, `fpga_mosi`=0, `fpga_config_busy`=0, all config registers 0, so `io_out`=0 and `io_oe`=0.
- `fpga_mode` is sampled in the first cycle after `fpga_rst` deasserts. Mode 0 goes to IDLE, with the SPI pins held at their reset values and the config left at 0.
- States: IDLE, CMD, DATA, DONE, FAIL.
- CMD: shift out 32 bits MSB-first: 8'h03 followed by `FLASH_ADDR`.
- DATA: shift in 128 bits MSB-first as four big-endian words:
  - W0 = sync word.
  - W1 = `cfg_oe`.
  - W2 = `cfg_val`.
  - W3 = `cfg_pass`.
- During DATA, `fpga_mosi`=0.
- The config registers update only on successful completion, all together in a single cycle. The final state is DONE.
- IO function in DONE:
  - `io_oe` = `cfg_oe`.
  - `io_out[i]` = `cfg_oe[i]` & (`cfg_pass[i]` ? `io_in[(i+16) mod 32]` : `cfg_val[i]`).
  - The pass-through path is combinational from `io_in`.
- FAIL: config registers stay 0, so `io_oe`=0. Only `fpga_rst` leaves DONE or FAIL.
- Reset mid-load aborts the transfer. On the next edge: `fpga_cs_n`=1, `fpga_sclk`=0, busy=0, config=0.

## Timing
- Cycle numbering: cycle 0 is the first edge with `fpga_rst`=0. Load start on that edge: busy=1, `fpga_cs_n`=0, `fpga_sclk`=0, `fpga_mosi` = CMD bit 31.
- Each bit takes 2·`CLK_DIV` cycles: `fpga_sclk` low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
- `fpga_mosi` changes only when `fpga_sclk` falls or at load start.
- `fpga_miso` is registered on the edge where `fpga_sclk` goes 0→1.
- Transfer length: 160 bits, i.e. 320·`CLK_DIV` cycles.
- End of transfer: on the edge ending the last high phase, `fpga_sclk`=0, `fpga_cs_n`=1 and busy=0. The config registers and state update on that same edge.
- Result latency: `io_out` and `io_oe` reflect the new config in the same cycle busy falls.
- Edge count: exactly 160 `fpga_sclk` rising edges per load; none in mode 0.

## Configuration
- Macro `HEICHIPS25_SYNC_CHECK_EN`.
- Defined: W0 ≠ `SYNC_WORD` ends in FAIL. The transfer still completes all 160 bits; busy falls at the normal time, and `io_oe` and `io_out` remain 0.
- Undefined: W0 is read and discarded, and every completed load ends in DONE.

## Test plan
- Mode 0: `fpga_mode`=0, release reset, run 1000 cycles -> busy=0, `fpga_cs_n`=1, no `fpga_sclk` edges, `io_oe`=0, `io_out`=0.
- Command check: `fpga_mode`=1, `FLASH_ADDR`=0 -> first 32 MOSI bits sampled on `fpga_sclk` rising edges = 32'h03000000; exactly 160 rising edges; busy high for 320 cycles (`CLK_DIV`=1).
- Static config: flash returns 5AA5C33C, 0000FFFF, 0000A5A5, 00000000 -> `io_oe`=32'h0000FFFF, `io_out`=32'h0000A5A5 once busy=0.
- Pass-through: flash returns 5AA5C33C, FFFF0000, 00000000, FFFF0000; drive `io_in`=32'h00001234 -> `io_out`=32'h12340000.
- Bad sync with `HEICHIPS25_SYNC_CHECK_EN` defined: W0=DEADBEEF, W1=FFFFFFFF -> busy falls after 320 cycles, `io_oe`=0. Without the macro: `io_oe`=FFFFFFFF.
- Reset mid-load: assert `fpga_rst` at cycle 100 -> next edge `fpga_cs_n`=1, busy=0. After release, a full reload completes correctly.
